// File: rtl/spi_slave_regfile_pkg.sv
// Shared types and helpers for the SPI slave register file.
package spi_slave_regfile_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    ADDR   = 3'd2,
    DATA   = 3'd3,
    IGNORE = 3'd4
  } state_t;

  // Value of the first frame bit that requests a read.
  localparam logic RW_READ = 1'b1;

  // Returns 1 when data is sampled on the rising sck edge.
  // Modes 0 and 3 sample on rising; modes 1 and 2 sample on falling.
  function automatic logic sample_on_rise(input int cpol, input int cpha);
    return (cpol == cpha);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for sck/ss_n/mosi with edge detection.
// Produces sample/shift strobes for the configured SPI mode and
// select edges.
// The ss_n chain resets to the "selected" level, so a frame already
// in progress when reset is released can never produce a falling
// edge. Such a frame stays invisible until ss_n has been seen high.
import spi_slave_regfile_pkg::*;

module spi_sync_edge #(
  parameter int CPOL = 0,
  parameter int CPHA = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_sck,
  input  logic i_ss_n,
  input  logic i_mosi,
  output logic o_mosi,
  output logic o_sample_stb,
  output logic o_shift_stb,
  output logic o_ss_fall,
  output logic o_ss_rise
);

  localparam logic SAMPLE_RISE = sample_on_rise(CPOL, CPHA);
  localparam logic SCK_IDLE    = (CPOL != 0);

  logic r_sck_s1, r_sck_s2, r_sck_d;
  logic r_ss_s1, r_ss_s2, r_ss_d;
  logic r_mosi_s1, r_mosi_s2;
  logic w_sck_rise, w_sck_fall;

  // Synchronise the three asynchronous SPI inputs and keep one delayed copy for edge detect.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sck_s1  <= SCK_IDLE;
      r_sck_s2  <= SCK_IDLE;
      r_sck_d   <= SCK_IDLE;
      r_ss_s1   <= 1'b0;
      r_ss_s2   <= 1'b0;
      r_ss_d    <= 1'b0;
      r_mosi_s1 <= 1'b0;
      r_mosi_s2 <= 1'b0;
    end else begin
      r_sck_s1  <= i_sck;
      r_sck_s2  <= r_sck_s1;
      r_sck_d   <= r_sck_s2;
      r_ss_s1   <= i_ss_n;
      r_ss_s2   <= r_ss_s1;
      r_ss_d    <= r_ss_s2;
      r_mosi_s1 <= i_mosi;
      r_mosi_s2 <= r_mosi_s1;
    end
  end

  assign w_sck_rise   = r_sck_s2 & ~r_sck_d;
  assign w_sck_fall   = ~r_sck_s2 & r_sck_d;
  assign o_sample_stb = SAMPLE_RISE ? w_sck_rise : w_sck_fall;
  assign o_shift_stb  = SAMPLE_RISE ? w_sck_fall : w_sck_rise;
  assign o_ss_fall    = ~r_ss_s2 & r_ss_d;
  assign o_ss_rise    = r_ss_s2 & ~r_ss_d;
  assign o_mosi       = r_mosi_s2;

endmodule

// File: rtl/spi_slave_regfile.sv
// SPI slave with an internal register file.
// Frame format, MSB first: R/W bit (1 = read), address, one or more
// data words. Committed writes appear on wr_*. The local host reads
// storage through host_addr/host_data.
// Optional burst mode: define SPI_SLAVE_REGFILE_AUTOINC_EN. The
// address then increments (wrapping) after each word while ss_n
// stays low. Without it, a frame ends after its first data word.
import spi_slave_regfile_pkg::*;

module spi_slave_regfile #(
  parameter int ADDR_BITS = 7,
  parameter int DATA_BITS = 8,
  parameter int CPOL      = 0,
  parameter int CPHA      = 0,
  parameter logic [DATA_BITS-1:0] RESET_VAL = {DATA_BITS{1'b0}}
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sck,
  input  logic                 ss_n,
  input  logic                 mosi,
  output logic                 miso,
  output logic                 miso_oe,
  output logic                 wr_valid,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic [DATA_BITS-1:0] wr_data,
  input  logic [ADDR_BITS-1:0] host_addr,
  output logic [DATA_BITS-1:0] host_data,
  output logic                 busy
);

  localparam int NUM_REGS = 1 << ADDR_BITS;
  localparam int MAX_BITS = (ADDR_BITS > DATA_BITS) ? ADDR_BITS : DATA_BITS;
  localparam int CNT_W    = $clog2(MAX_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_A = CNT_W'(ADDR_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_D = CNT_W'(DATA_BITS - 1);

  logic w_mosi, w_sample_stb, w_shift_stb, w_ss_fall, w_ss_rise;

  spi_sync_edge #(
    .CPOL (CPOL),
    .CPHA (CPHA)
  ) u_sync (
    .clk          (clk),
    .reset        (reset),
    .i_sck        (sck),
    .i_ss_n       (ss_n),
    .i_mosi       (mosi),
    .o_mosi       (w_mosi),
    .o_sample_stb (w_sample_stb),
    .o_shift_stb  (w_shift_stb),
    .o_ss_fall    (w_ss_fall),
    .o_ss_rise    (w_ss_rise)
  );

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_is_read;
  logic [ADDR_BITS-1:0] r_addr;
  logic [DATA_BITS-1:0] r_data;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_miso, r_miso_oe, r_wr_valid, r_busy;
  logic [ADDR_BITS-1:0] r_wr_addr;
  logic [DATA_BITS-1:0] r_wr_data;
  logic [DATA_BITS-1:0] r_host_data;
  logic [DATA_BITS-1:0] r_mem [NUM_REGS];

  logic [ADDR_BITS-1:0] w_addr_next;
  logic [DATA_BITS-1:0] w_word;
  logic                 w_wr_en;

  // Sampled bit appended at the LSB of the partial address / data word.
  assign w_addr_next = ADDR_BITS'({r_addr, w_mosi});
  assign w_word      = DATA_BITS'({r_data, w_mosi});

  // A write commits on the last sample of a complete word, unless select is rising in the same clk.
  assign w_wr_en = (r_state == DATA) && w_sample_stb && !w_ss_rise &&
                   (r_cnt == LAST_D) && (r_is_read != RW_READ);

`ifdef SPI_SLAVE_REGFILE_AUTOINC_EN
  logic [ADDR_BITS-1:0] w_addr_inc;
  assign w_addr_inc = r_addr + 1'b1;
`endif

  // Frame decoder: command/address/data sequencing, read shifter, and write strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= {CNT_W{1'b0}};
      r_is_read  <= 1'b0;
      r_addr     <= {ADDR_BITS{1'b0}};
      r_data     <= {DATA_BITS{1'b0}};
      r_shift    <= {DATA_BITS{1'b0}};
      r_miso     <= 1'b0;
      r_miso_oe  <= 1'b0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= {ADDR_BITS{1'b0}};
      r_wr_data  <= {DATA_BITS{1'b0}};
      r_busy     <= 1'b0;
    end else begin
      r_wr_valid <= 1'b0;
      if (w_ss_rise) begin
        r_state   <= IDLE;
        r_cnt     <= {CNT_W{1'b0}};
        r_miso    <= 1'b0;
        r_miso_oe <= 1'b0;
        r_busy    <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_ss_fall) begin
              r_state <= CMD;
              r_cnt   <= {CNT_W{1'b0}};
              r_busy  <= 1'b1;
            end
          end
          CMD: begin
            if (w_sample_stb) begin
              r_is_read <= (w_mosi == RW_READ);
              r_state   <= ADDR;
              r_cnt     <= {CNT_W{1'b0}};
            end
          end
          ADDR: begin
            if (w_sample_stb) begin
              r_addr <= w_addr_next;
              if (r_cnt == LAST_A) begin
                r_state <= DATA;
                r_cnt   <= {CNT_W{1'b0}};
                r_shift <= r_mem[w_addr_next];
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end
          end
          DATA: begin
            if (w_sample_stb) begin
              r_data <= w_word;
              if (r_cnt == LAST_D) begin
                r_cnt <= {CNT_W{1'b0}};
                if (r_is_read != RW_READ) begin
                  r_wr_valid <= 1'b1;
                  r_wr_addr  <= r_addr;
                  r_wr_data  <= w_word;
                end
`ifdef SPI_SLAVE_REGFILE_AUTOINC_EN
                r_addr  <= w_addr_inc;
                r_shift <= r_mem[w_addr_inc];
`else
                r_state   <= IGNORE;
                r_miso    <= 1'b0;
                r_miso_oe <= 1'b0;
`endif
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end else if (w_shift_stb && (r_is_read == RW_READ)) begin
              r_miso    <= r_shift[DATA_BITS-1];
              r_shift   <= r_shift << 1;
              r_miso_oe <= 1'b1;
            end
          end
          IGNORE: begin
            r_miso    <= 1'b0;
            r_miso_oe <= 1'b0;
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  // Register storage and registered host read port.
  // A host read in the same clk as a write returns the old value.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_mem[i] <= RESET_VAL;
      end
      r_host_data <= {DATA_BITS{1'b0}};
    end else begin
      if (w_wr_en) begin
        r_mem[r_addr] <= w_word;
      end
      r_host_data <= r_mem[host_addr];
    end
  end

  assign miso      = r_miso;
  assign miso_oe   = r_miso_oe;
  assign wr_valid  = r_wr_valid;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign host_data = r_host_data;
  assign busy      = r_busy;

endmodule
